// File: rtl/apb_master_bridge_if.sv
// APB bus between the apb_master_bridge requester and an APB completer.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Converts single-beat valid/ready commands into APB SETUP/ACCESS transfers with PREADY waits.
// Define APB_TIMEOUT_EN to add an ACCESS-phase watchdog that aborts after TIMEOUT cycles.
module apb_master_bridge #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                busy,
    apb_master_bridge_if.master apb
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              access_done;
    logic              access_abort;
    logic              psel_nxt;
    logic              penable_nxt;
    logic              pwrite_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic              rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic              rsp_err_nxt;

    // A zero watchdog limit would abort before the first ACCESS cycle could complete.
    if (TIMEOUT < 1) begin : g_timeout_out_of_range
    end

    assign cmd_ready   = (state == IDLE);
    assign busy        = ~cmd_ready;
    assign access_done = (state == ACCESS) && apb.PREADY;

`ifdef APB_TIMEOUT_EN
    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             rsp_timeout_nxt;

    assign access_abort = (state == ACCESS) && !apb.PREADY && (wd_cnt == WD_LAST);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wd_cnt <= '0;
        end else if (state == SETUP) begin
            wd_cnt <= '0;
        end else if ((state == ACCESS) && !apb.PREADY) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rsp_timeout <= 1'b0;
        end else begin
            rsp_timeout <= rsp_timeout_nxt;
        end
    end
`else
    assign access_abort = 1'b0;
    assign rsp_timeout  = 1'b0;
`endif

    // NOTE: the reset is synchronous, so it lives inside the clocked branch and not in the sensitivity list.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaulting every comb output first means no path can leave it unassigned and infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (access_done || access_abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered APB and response outputs; bus fields hold unless a command is accepted.
    always_comb begin
        psel_nxt      = apb.PSEL;
        penable_nxt   = apb.PENABLE;
        pwrite_nxt    = apb.PWRITE;
        paddr_nxt     = apb.PADDR;
        pwdata_nxt    = apb.PWDATA;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
`ifdef APB_TIMEOUT_EN
        rsp_timeout_nxt = rsp_timeout;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    pwrite_nxt  = cmd_write;
                    paddr_nxt   = cmd_addr;
                    pwdata_nxt  = cmd_wdata;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (access_done) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = apb.PWRITE ? '0 : apb.PRDATA;
                    rsp_err_nxt   = apb.PSLVERR;
`ifdef APB_TIMEOUT_EN
                    rsp_timeout_nxt = 1'b0;
`endif
                end else if (access_abort) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
`ifdef APB_TIMEOUT_EN
                    rsp_timeout_nxt = 1'b1;
`endif
                end
            end
            default: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: registered state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            apb.PSEL    <= psel_nxt;
            apb.PENABLE <= penable_nxt;
            apb.PWRITE  <= pwrite_nxt;
            apb.PADDR   <= paddr_nxt;
            apb.PWDATA  <= pwdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed and randomized bench for apb_master_bridge; an array models the APB completer's storage.
// Build with +define+APB_TIMEOUT_EN to exercise the watchdog abort path.
module tb_apb_master_bridge;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic              PCLK;
    logic              PRESETn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;

    apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .apb         (apb)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int          n_vec;
    int          n_mis;
    logic [7:0]  mem [8];
    logic [7:0]  exp_rdata;
    logic        exp_err;
    logic        exp_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in an IDLE cycle; returns at the negedge of the response cycle.
    task automatic xfer(input bit wr, input logic [2:0] a, input logic [7:0] d,
                        input int waits, input bit err, input logic [7:0] rd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        check("accept_ready", cmd_ready, 1);
        @(negedge PCLK);
        cmd_write   = 1'($urandom);
        cmd_addr    = 3'($urandom);
        cmd_wdata   = 8'($urandom);
        apb.PREADY  = 1'($urandom);
        apb.PSLVERR = 1'($urandom);
        check("setup_psel", apb.PSEL, 1);
        check("setup_penable", apb.PENABLE, 0);
        check("setup_paddr", apb.PADDR, a);
        check("setup_pwrite", apb.PWRITE, wr);
        check("setup_pwdata", apb.PWDATA, d);
        check("setup_busy", busy, 1);
        check("setup_rsp_valid", rsp_valid, 0);
        for (int i = 0; i <= waits; i++) begin
            @(negedge PCLK);
            check("access_psel", apb.PSEL, 1);
            check("access_penable", apb.PENABLE, 1);
            check("access_paddr", apb.PADDR, a);
            check("access_pwrite", apb.PWRITE, wr);
            check("access_pwdata", apb.PWDATA, d);
            check("access_cmd_ready", cmd_ready, 0);
            check("access_rsp_valid", rsp_valid, 0);
            apb.PREADY  = (i == waits);
            apb.PSLVERR = (i == waits) ? err : 1'($urandom);
            apb.PRDATA  = (i == waits) ? rd : 8'($urandom);
        end
        @(negedge PCLK);
        exp_rdata = wr ? 8'h00 : rd;
        exp_err   = err;
        exp_to    = 1'b0;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_timeout", rsp_timeout, exp_to);
        check("rsp_psel", apb.PSEL, 0);
        check("rsp_penable", apb.PENABLE, 0);
        check("rsp_cmd_ready", cmd_ready, 1);
        check("rsp_busy", busy, 0);
        check("rsp_paddr_hold", apb.PADDR, a);
        check("rsp_pwdata_hold", apb.PWDATA, d);
        cmd_valid   = 1'b0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'($urandom);
        apb.PRDATA  = 8'($urandom);
    endtask

    task automatic idle_cycle();
        @(negedge PCLK);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_rdata_hold", rsp_rdata, exp_rdata);
        check("idle_err_hold", rsp_err, exp_err);
        check("idle_timeout_hold", rsp_timeout, exp_to);
    endtask

    bit         r_wr;
    bit         r_err;
    logic [2:0] r_addr;
    logic [7:0] r_data;
    int         r_waits;
    int         r_gap;
    int         pen_cnt;
    int         rsp_cnt;
    int         idle_cnt;

    initial begin
        n_vec       = 0;
        n_mis       = 0;
        PRESETn     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        apb.PRDATA  = '0;
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        exp_rdata = 8'h00;
        exp_err   = 1'b0;
        exp_to    = 1'b0;

        // Reset state.
        repeat (2) @(negedge PCLK);
        check("rst_psel", apb.PSEL, 0);
        check("rst_penable", apb.PENABLE, 0);
        check("rst_pwrite", apb.PWRITE, 0);
        check("rst_paddr", apb.PADDR, 0);
        check("rst_pwdata", apb.PWDATA, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        PRESETn = 1'b1;
        idle_cycle();

        // Zero-wait write.
        xfer(1'b1, 3'd0, 8'h1C, 0, 1'b0, mem[0]);
        mem[0] = 8'h1C;
        idle_cycle();

        // Read with three wait states.
        mem[5] = 8'hA5;
        xfer(1'b0, 3'd5, 8'h00, 3, 1'b0, mem[5]);
        idle_cycle();

        // Slave error on a write leaves storage untouched.
        xfer(1'b1, 3'd2, 8'hC3, 1, 1'b1, mem[2]);
        idle_cycle();

        // Back-to-back: second command offered in the first response cycle.
        xfer(1'b1, 3'd1, 8'h82, 0, 1'b0, mem[1]);
        mem[1] = 8'h82;
        xfer(1'b0, 3'd1, 8'h5E, 0, 1'b0, mem[1]);
        idle_cycle();

        // PREADY arriving on the last cycle before the watchdog limit completes normally.
        mem[4] = 8'h3D;
        xfer(1'b0, 3'd4, 8'h00, TIMEOUT - 1, 1'b0, mem[4]);
        idle_cycle();

        // Randomized traffic against the storage model.
        for (int t = 0; t < 40; t++) begin
            r_wr    = 1'($urandom);
            r_addr  = 3'($urandom);
            r_data  = 8'($urandom);
            r_waits = $urandom_range(0, 5);
            r_err   = ($urandom_range(0, 7) == 0);
            xfer(r_wr, r_addr, r_data, r_waits, r_err, mem[r_addr]);
            if (r_wr && !r_err) mem[r_addr] = r_data;
            r_gap = $urandom_range(0, 2);
            for (int g = 0; g < r_gap; g++) idle_cycle();
        end

        // Reset during ACCESS discards the transfer.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 3'd6;
        cmd_wdata = 8'h77;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        check("mid_in_access", apb.PENABLE, 1);
        PRESETn = 1'b0;
        @(negedge PCLK);
        check("mid_rst_psel", apb.PSEL, 0);
        check("mid_rst_penable", apb.PENABLE, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_paddr", apb.PADDR, 0);
        check("mid_rst_rdata", rsp_rdata, 0);
        PRESETn   = 1'b1;
        exp_rdata = 8'h00;
        exp_err   = 1'b0;
        exp_to    = 1'b0;
        idle_cycle();

        // PREADY held low forever.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 3'd3;
        cmd_wdata = 8'h5A;
        check("hang_accept", cmd_ready, 1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        pen_cnt   = 0;
        rsp_cnt   = 0;
        idle_cnt  = 0;
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 40 && rsp_cnt == 0; i++) begin
            @(negedge PCLK);
            apb.PSLVERR = 1'($urandom);
            apb.PRDATA  = 8'($urandom);
            if (apb.PENABLE) pen_cnt++;
            if (rsp_valid) rsp_cnt++;
        end
        exp_rdata = 8'h00;
        exp_err   = 1'b1;
        exp_to    = 1'b1;
        check("to_rsp_seen", rsp_cnt, 1);
        check("to_penable_cycles", pen_cnt, TIMEOUT);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_psel", apb.PSEL, 0);
        check("to_cmd_ready", cmd_ready, 1);
        idle_cycle();
`else
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            apb.PSLVERR = 1'($urandom);
            if (apb.PENABLE) pen_cnt++;
            if (rsp_valid) rsp_cnt++;
            if (!busy) idle_cnt++;
        end
        check("hang_no_rsp", rsp_cnt, 0);
        check("hang_busy_low_cycles", idle_cnt, 0);
        check("hang_penable_cycles", pen_cnt, 100);
        check("hang_timeout_tied", rsp_timeout, 0);
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        exp_rdata = 8'h00;
        exp_err   = 1'b0;
        exp_to    = 1'b0;
        idle_cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester that drives the PSEL/PENABLE/PADDR/PWRITE/PWDATA side of the SPI peripheral's APB slave interface.
- Converts single-beat commands from a local valid/ready command port into APB SETUP/ACCESS transfers.
- Honours PREADY wait states and returns read data and error status on a response port.
- Sits between the system/CPU model and the SPI APB slave.

Parameters:
- ADDR_W, 3, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT, 16, max ACCESS cycles before abort (only used with APB_TIMEOUT_EN; must be >=1).

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by watchdog.
- busy  out  1  transfer in progress.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset (PRESETn=0 at a rising edge): state=IDLE; every registered output cleared to 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout); watchdog counter cleared.
- Reset mid-transfer: PSEL/PENABLE drop at that edge, the transfer is discarded, and no response is issued.
- cmd_ready = (state==IDLE), combinational. busy = !cmd_ready.
- IDLE:
  - On cmd_valid && cmd_ready: register PADDR=cmd_addr, PWRITE=cmd_write, PWDATA=cmd_wdata; set PSEL=1, PENABLE=0; go to SETUP.
  - cmd_* values are sampled only at acceptance.
- SETUP (exactly 1 cycle): set PENABLE=1; go to ACCESS.
- ACCESS, PREADY=0: hold all APB outputs stable.
- ACCESS, PREADY=1:
  - Clear PSEL and PENABLE; go to IDLE.
  - Set rsp_valid=1; rsp_rdata = PWRITE ? 0 : PRDATA; rsp_err = PSLVERR; rsp_timeout = 0.
- rsp_valid is high for exactly one cycle and has no backpressure. rsp_rdata/rsp_err/rsp_timeout hold their values until the next response.
- PADDR/PWRITE/PWDATA keep their last values after the transfer completes.
- Latency: acceptance edge N; SETUP is cycle N+1; first ACCESS is cycle N+2; with zero wait states rsp_valid is high in cycle N+3.
  - The cycle with rsp_valid is IDLE, so the next command can be accepted there.
  - Back-to-back throughput: one transfer per 3 cycles.
- PSLVERR and PRDATA are sampled only in ACCESS with PREADY=1. Values at any other time are ignored.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Enabled:
  - Watchdog counter, width $clog2(TIMEOUT+1), cleared on entering ACCESS.
  - Increments each ACCESS cycle with PREADY=0.
  - In an ACCESS cycle with PREADY=0 and counter==TIMEOUT-1, at that edge: abort; clear PSEL/PENABLE; go to IDLE; rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Result: PENABLE is high exactly TIMEOUT cycles on abort.
  - PREADY=1 in the same cycle as the limit completes the transfer normally.
- Disabled: no counter; ACCESS waits indefinitely; rsp_timeout is tied 0.

Test Plan:
- Write 0x1C to addr 0, PREADY=1 tied:
  - PSEL high 2 cycles, PENABLE high 1 cycle, PWRITE=1, PWDATA=0x1C.
  - rsp_valid in cycle N+3 with rsp_err=0, rsp_rdata=0.
- Read addr 5, PREADY low for 3 ACCESS cycles then high with PRDATA=0xA5:
  - PENABLE high 4 cycles, APB outputs stable throughout.
  - rsp_rdata=0xA5, rsp_err=0.
- Write 0xC3 to addr 2 with PSLVERR=1 at the PREADY=1 cycle: rsp_err=1, rsp_timeout=0.
- cmd_valid held continuously with two commands (write addr 1 = 0x82, read addr 1):
  - Second command accepted in the rsp_valid cycle of the first.
  - Second PSEL rises 1 cycle later; no idle bubble beyond that.
- Reset asserted during ACCESS (PREADY=0): at that edge PSEL=PENABLE=0, no rsp_valid, cmd_ready=1 after reset releases.
- With APB_TIMEOUT_EN, TIMEOUT=16, PREADY held 0:
  - PENABLE high exactly 16 cycles, then rsp_valid=1, rsp_err=1, rsp_timeout=1.
  - Without the macro, no response after 100 cycles and busy stays 1.
